compression_gain_applier: RTL and testbench

- Back end of the compressor path: consumes the attenuation (dB) that the gain computer produces and applies it to an audio sample.
- Converts whole-dB attenuation to a linear Q1.15 gain by iterative divide-by-6, a 6-entry ROM and a right shift.
- Multiplies the sample by that gain, rounds, and returns it with a start/done handshake.
- Sits between the gain computer's level output and the audio output path.

---
 rtl/compression_gain_applier.sv | 119 +++++++++++
 tb/tb_compression_gain_applier.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/compression_gain_applier.sv
`default_nettype none
// ============================================================================
// Module      : compression_gain_applier
// Description : Converts whole-dB attenuation to a Q1.15 gain and applies it
//               to a signed sample with a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module compression_gain_applier #(
  parameter int WIDTH     = 8,
  parameter int MAX_ATTEN = 96
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [8:0]              attenuation_db,
  input  logic signed [WIDTH-1:0] sample_in,
  output logic signed [WIDTH-1:0] sample_out,
  output logic [15:0]             gain_linear,
  output logic                    busy,
  output logic                    done
);

  localparam logic [8:0]               c_MAX_ATTEN = 9'(MAX_ATTEN);
  localparam logic [8:0]               c_STEP_DB   = 9'd6;
  localparam logic signed [WIDTH+16:0] c_HALF      = (WIDTH+17)'(16384);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DIVIDE   = 3'd1,
    S_SCALE    = 3'd2,
    S_ZERO     = 3'd3,
    S_MULTIPLY = 3'd4,
    S_OUTPUT   = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [8:0]                r_rem;
  logic [3:0]                r_q;
  logic signed [WIDTH-1:0]   r_samp;
  logic signed [WIDTH+16:0]  r_prod;
  logic [15:0]               w_rom;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (attenuation_db < c_MAX_ATTEN) ? S_DIVIDE : S_ZERO;
      end
      S_DIVIDE:   if (r_rem < c_STEP_DB) w_next = S_SCALE;
      S_SCALE:    w_next = S_MULTIPLY;
      S_ZERO:     w_next = S_MULTIPLY;
      S_MULTIPLY: w_next = S_OUTPUT;
      S_OUTPUT:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // Fractional-dB mantissa: round(10^(-r/20) * 32768); whole 6 dB steps become shifts
  always_comb begin
    w_rom = 16'd32768;
    case (r_rem[2:0])
      3'd0:    w_rom = 16'd32768;
      3'd1:    w_rom = 16'd29205;
      3'd2:    w_rom = 16'd26029;
      3'd3:    w_rom = 16'd23198;
      3'd4:    w_rom = 16'd20675;
      3'd5:    w_rom = 16'd18427;
      default: w_rom = 16'd32768;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_samp      <= '0;
      r_prod      <= '0;
      gain_linear <= '0;
      sample_out  <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem  <= attenuation_db;
            r_samp <= sample_in;
            r_q    <= '0;
          end
        end
        S_DIVIDE: begin
          if (r_rem >= c_STEP_DB) begin
            r_rem <= r_rem - c_STEP_DB;
            r_q   <= r_q + 4'd1;
          end
        end
        S_SCALE:    gain_linear <= w_rom >> r_q;
        S_ZERO:     gain_linear <= '0;
        // Gain is unsigned Q1.15, so it gets a zero sign bit before the signed multiply
        S_MULTIPLY: r_prod <= r_samp * $signed({1'b0, gain_linear});
        S_OUTPUT: begin
          sample_out <= WIDTH'((r_prod + c_HALF) >>> 15);
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compression_gain_applier.sv
`default_nettype none
// Testbench for compression_gain_applier: table-driven vectors with a
// scoreboard queue plus hand-written back-to-back, busy and reset sequences.
module tb_compression_gain_applier;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic [8:0]        attenuation_db;
  logic signed [7:0] sample_in;
  logic signed [7:0] sample_out;
  logic [15:0]       gain_linear;
  logic              busy;
  logic              done;

  compression_gain_applier #(.WIDTH(8), .MAX_ATTEN(96)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .attenuation_db (attenuation_db),
    .sample_in      (sample_in),
    .sample_out     (sample_out),
    .gain_linear    (gain_linear),
    .busy           (busy),
    .done           (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [8:0]        atten;
    logic signed [7:0] samp;
    logic [15:0]       gain;
    logic signed [7:0] out;
    int                lat;
  } vec_t;

  typedef struct {
    logic [15:0]       gain;
    logic signed [7:0] out;
    int                lat;
    int                t0;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   cyc = 0;
  int   done_count = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled by the following posedge
  task automatic drive_start(input logic [8:0] a, input logic signed [7:0] s,
                             input logic [15:0] g, input logic signed [7:0] o,
                             input int lat, input bit push);
    exp_t e;
    attenuation_db = a;
    sample_in      = s;
    start          = 1'b1;
    if (push) begin
      e.gain = g; e.out = o; e.lat = lat; e.t0 = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clock);
    start          = 1'b0;
    attenuation_db = 9'h1AA;
    sample_in      = 8'sd77;
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got done expected no output", name);
      return;
    end
    e = sb.pop_front();
    chk({name, " sample_out"}, int'(sample_out), int'(e.out));
    chk({name, " gain"}, int'(gain_linear), int'(e.gain));
    chk({name, " latency"}, cyc - e.t0, e.lat);
  endtask

  initial begin
    bit ok;
    int dc;
    vecs[0]  = '{9'd0,   8'sd100,  16'd32768, 8'sd100, 4};
    vecs[1]  = '{9'd6,   8'sd100,  16'd16384, 8'sd50,  5};
    vecs[2]  = '{9'd3,   -8'sd128, 16'd23198, -8'sd91, 4};
    vecs[3]  = '{9'd95,  -8'sd128, 16'd0,     8'sd0,   19};
    vecs[4]  = '{9'd1,   -8'sd1,   16'd29205, -8'sd1,  4};
    vecs[5]  = '{9'd13,  8'sd127,  16'd7301,  8'sd28,  6};
    vecs[6]  = '{9'd12,  -8'sd100, 16'd8192,  -8'sd25, 6};
    vecs[7]  = '{9'd6,   -8'sd1,   16'd16384, 8'sd0,   5};
    vecs[8]  = '{9'd90,  8'sd127,  16'd1,     8'sd0,   19};
    vecs[9]  = '{9'd200, -8'sd7,   16'd0,     8'sd0,   3};
    vecs[10] = '{9'd511, 8'sd127,  16'd0,     8'sd0,   3};
    vecs[11] = '{9'd5,   8'sd64,   16'd18427, 8'sd36,  4};

    reset_n = 1'b0;
    start = 1'b0;
    attenuation_db = '0;
    sample_in = '0;
    repeat (3) @(negedge clock);
    chk("reset sample_out", int'(sample_out), 0);
    chk("reset gain", int'(gain_linear), 0);
    chk("reset done", int'(done), 0);
    chk("reset busy", int'(busy), 0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      drive_start(vecs[i].atten, vecs[i].samp, vecs[i].gain, vecs[i].out, vecs[i].lat, 1'b1);
      wait_done($sformatf("vec%0d", i), ok);
      if (ok) check_pop($sformatf("vec%0d", i));
      else sb.delete();
      @(negedge clock);
    end

    // Back-to-back: second start issued in the done cycle of the first
    drive_start(9'd20, 8'sd127, 16'd3253, 8'sd13, 7, 1'b1);
    wait_done("b2b first", ok);
    if (ok) begin
      check_pop("b2b first");
      drive_start(9'd96, 8'sd55, 16'd0, 8'sd0, 3, 1'b1);
      wait_done("b2b second", ok);
      if (ok) check_pop("b2b second");
    end
    sb.delete();
    repeat (2) @(negedge clock);

    // Start pulsed while busy is ignored; exactly one done
    dc = done_count;
    drive_start(9'd12, 8'sd40, 16'd8192, 8'sd10, 6, 1'b1);
    @(negedge clock);
    drive_start(9'd0, -8'sd50, 16'd0, 8'sd0, 0, 1'b0);
    wait_done("busy ignore", ok);
    if (ok) begin
      check_pop("busy ignore");
      @(negedge clock);
      chk("done width", int'(done), 0);
    end
    sb.delete();
    repeat (25) @(negedge clock);
    chk("busy ignore done count", done_count - dc, 1);
    chk("busy ignore idle", int'(busy), 0);

    // Reset in DIVIDE aborts with no done pulse
    dc = done_count;
    drive_start(9'd60, 8'sd100, 16'd0, 8'sd0, 0, 1'b0);
    repeat (3) @(negedge clock);
    chk("pre-reset busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("async reset sample_out", int'(sample_out), 0);
    chk("async reset gain", int'(gain_linear), 0);
    chk("async reset busy", int'(busy), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    chk("abort done count", done_count - dc, 0);
    chk("abort idle", int'(busy), 0);

    drive_start(9'd4, 8'sd100, 16'd20675, 8'sd63, 4, 1'b1);
    wait_done("after reset", ok);
    if (ok) check_pop("after reset");
    sb.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
